// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - core bring-up sequencer: core reset release, fetch_enable pulse train, debug halt/step
module boot_sequencer #(
  parameter int RST_HOLD_CYCLES = 1,
  parameter int START_DELAY     = 4,
  parameter int PULSE_WIDTH     = 1,
  parameter int PULSE_GAP       = 4,
  parameter int NUM_PULSES      = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             core_reset_n,
  output logic             fetch_enable,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic [CNT_W-1:0] pulse_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_DELAY,
    S_PULSE,
    S_GAP,
    S_HALTED,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] WIDTH_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(PULSE_GAP - 1);
  localparam logic [CNT_W-1:0] NUM_P      = CNT_W'(NUM_PULSES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  // With no start delay a run begins directly in PULSE; DELAY is never entered.
  localparam state_t RUN_ENTRY = (START_DELAY == 0) ? S_PULSE : S_DELAY;

  state_t           state, state_nx;
  logic [CNT_W-1:0] phase_cnt, phase_cnt_nx;
  logic [CNT_W-1:0] pulse_count_nx, pulse_sat_inc;
  logic             is_step, is_step_nx;

  assign pulse_sat_inc = (pulse_count == CNT_MAX) ? pulse_count : pulse_count + 1'b1;

  always_comb begin
    state_nx       = state;
    phase_cnt_nx   = '0;
    pulse_count_nx = pulse_count;
    is_step_nx     = is_step;
    case (state)
      S_RST_HOLD: begin
        if (phase_cnt == HOLD_LAST) state_nx = RUN_ENTRY;
        else                        phase_cnt_nx = phase_cnt + 1'b1;
      end
      S_DELAY: begin
        if (halt_req)                     state_nx = S_HALTED;
        else if (phase_cnt == DELAY_LAST) state_nx = S_PULSE;
        else                              phase_cnt_nx = phase_cnt + 1'b1;
      end
      S_GAP: begin
        if (halt_req)                   state_nx = S_HALTED;
        else if (phase_cnt == GAP_LAST) state_nx = S_PULSE;
        else                            phase_cnt_nx = phase_cnt + 1'b1;
      end
      S_PULSE: begin
        // A pulse always runs its full width; halt is only honoured at its end.
        if (phase_cnt == WIDTH_LAST) begin
          pulse_count_nx = pulse_sat_inc;
          is_step_nx     = 1'b0;
          if ((NUM_P != '0) && (pulse_sat_inc == NUM_P)) state_nx = S_DONE;
          else if (halt_req || is_step)                  state_nx = S_HALTED;
          else                                           state_nx = S_GAP;
        end else begin
          phase_cnt_nx = phase_cnt + 1'b1;
        end
      end
      S_HALTED: begin
        if (step_req) begin
          state_nx   = S_PULSE;
          is_step_nx = 1'b1;
        end else if (!halt_req) begin
          state_nx = S_GAP;
        end
      end
      S_DONE: begin
        if (start) begin
          pulse_count_nx = '0;
          state_nx       = RUN_ENTRY;
        end
      end
      default: state_nx = S_RST_HOLD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_RST_HOLD;
      phase_cnt   <= '0;
      pulse_count <= '0;
      cycle_count <= '0;
      is_step     <= 1'b0;
    end else begin
      state       <= state_nx;
      phase_cnt   <= phase_cnt_nx;
      pulse_count <= pulse_count_nx;
      is_step     <= is_step_nx;
      if ((state != S_RST_HOLD) && (cycle_count != CNT_MAX))
        cycle_count <= cycle_count + 1'b1;
    end
  end

  assign core_reset_n = (state != S_RST_HOLD);
  assign fetch_enable = (state == S_PULSE);
  assign busy         = (state != S_DONE) && (state != S_HALTED);
  assign done         = (state == S_DONE);
  assign halted       = (state == S_HALTED);

endmodule
